decoder_3to8: RTL and testbench

3-to-8 line decoder with a registered, enable-gated one-hot output. Three select bits x (MSB), y, z (LSB) form index {x,y,z}. Exactly one of eight output lines is asserted per cycle, or none when disabled or in reset. Used as a general select/chip-enable generator wherever a 3-bit code drives one-of-eight selection.

---
 rtl/decoder_3to8_if.sv | 20 ++
 rtl/decoder_3to8.sv | 55 +++++
 tb/tb_decoder_3to8.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_3to8_if.sv
// Select/enable inputs and decoded outputs of the 3-to-8 decoder.
// master drives the select code; slave is the decoder itself.
interface decoder_3to8_if;
  logic       en;
  logic       x;
  logic       y;
  logic       z;
  logic [7:0] d;
  logic       valid;

  modport master (
    output en, x, y, z,
    input  d, valid
  );

  modport slave (
    input  en, x, y, z,
    output d, valid
  );
endinterface

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with enable, optional output register and optional
// active-low output polarity.
module decoder_3to8 #(
  parameter bit REGISTERED     = 1'b1,
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  decoder_3to8_if.slave bus
);

  logic [7:0] d_raw;
  logic [7:0] d_q;
  logic       valid_q;

  always_comb begin
    d_raw = 8'h00;
    d_raw[{bus.x, bus.y, bus.z}] = bus.en;
  end

  if (REGISTERED) begin : g_reg
    logic [7:0] d_d;
    logic       valid_d;

    always_comb begin
      d_d     = d_raw;
      valid_d = bus.en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q     <= 8'h00;
        valid_q <= 1'b0;
      end else begin
        d_q     <= d_d;
        valid_q <= valid_d;
      end
    end
  end else begin : g_comb
    // No storage: reset only masks the live decode.
    always_comb begin
      d_q     = 8'h00;
      valid_q = 1'b0;
      if (rst_n) begin
        d_q     = d_raw;
        valid_q = bus.en;
      end
    end
  end

  // Polarity is applied after the register so reset yields the inactive level.
  assign bus.d     = ACTIVE_LOW_OUT ? ~d_q : d_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Randomized self-checking bench: registered, active-low and combinational
// builds driven in lockstep and compared against an index-to-one-hot model.
module tb_decoder_3to8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  decoder_3to8_if if_reg ();
  decoder_3to8_if if_low ();
  decoder_3to8_if if_comb ();

  assign if_low.en  = if_reg.en;
  assign if_low.x   = if_reg.x;
  assign if_low.y   = if_reg.y;
  assign if_low.z   = if_reg.z;
  assign if_comb.en = if_reg.en;
  assign if_comb.x  = if_reg.x;
  assign if_comb.y  = if_reg.y;
  assign if_comb.z  = if_reg.z;

  decoder_3to8 #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .bus(if_reg)
  );
  decoder_3to8 #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b1)) dut_low (
    .clk(clk), .rst_n(rst_n), .bus(if_low)
  );
  decoder_3to8 #(.REGISTERED(1'b0), .ACTIVE_LOW_OUT(1'b0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .bus(if_comb)
  );

  // Active-high reference: line number 4x+2y+z is set when enabled.
  function automatic logic [7:0] model(input logic e, input int idx);
    logic [7:0] v;
    v = 8'h00;
    if (e) v = 8'(2 ** idx);
    return v;
  endfunction

  task automatic drive(input logic e, input int idx);
    logic [2:0] s;
    s = 3'(idx);
    if_reg.en = e;
    if_reg.x  = s[2];
    if_reg.y  = s[1];
    if_reg.z  = s[0];
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 7);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (if_reg.d !== 8'h00 || if_reg.valid !== 1'b0) begin
      $display("FAIL reset_reg: got d=%h valid=%b want d=00 valid=0", if_reg.d, if_reg.valid);
      miscompares++;
    end
    vectors++;
    if (if_low.d !== 8'hFF || if_low.valid !== 1'b0) begin
      $display("FAIL reset_low: got d=%h valid=%b want d=ff valid=0", if_low.d, if_low.valid);
      miscompares++;
    end
    vectors++;
    if (if_comb.d !== 8'h00 || if_comb.valid !== 1'b0) begin
      $display("FAIL reset_comb: got d=%h valid=%b want d=00 valid=0", if_comb.d, if_comb.valid);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (if_reg.d !== 8'h80 || if_reg.valid !== 1'b1) begin
      $display("FAIL reset_release: got d=%h valid=%b want d=80 valid=1", if_reg.d, if_reg.valid);
      miscompares++;
    end
    // Assert reset between edges; outputs must clear without a clock.
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (if_reg.d !== 8'h00 || if_reg.valid !== 1'b0 || if_low.d !== 8'hFF) begin
      $display("FAIL reset_async: got reg=%h valid=%b low=%h want 00 0 ff",
               if_reg.d, if_reg.valid, if_low.d);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, i);
      @(posedge clk);
      #1;
      vectors++;
      if (if_reg.d !== model(1'b1, i) || if_reg.valid !== 1'b1) begin
        $display("FAIL sweep_%0d: got d=%h valid=%b want d=%h valid=1",
                 i, if_reg.d, if_reg.valid, model(1'b1, i));
        miscompares++;
      end
    end
  endtask

  task automatic test_enable();
    @(negedge clk);
    drive(1'b0, 5);
    @(posedge clk);
    #1;
    vectors++;
    if (if_reg.d !== 8'h00 || if_reg.valid !== 1'b0) begin
      $display("FAIL enable_off: got d=%h valid=%b want d=00 valid=0", if_reg.d, if_reg.valid);
      miscompares++;
    end
    @(negedge clk);
    drive(1'b1, 5);
    @(posedge clk);
    #1;
    vectors++;
    if (if_reg.d !== 8'h20 || if_reg.valid !== 1'b1) begin
      $display("FAIL enable_on: got d=%h valid=%b want d=20 valid=1", if_reg.d, if_reg.valid);
      miscompares++;
    end
  endtask

  task automatic test_active_low();
    @(negedge clk);
    drive(1'b1, 3);
    @(posedge clk);
    #1;
    vectors++;
    if (if_low.d !== 8'hF7 || if_low.valid !== 1'b1) begin
      $display("FAIL low_011: got d=%h valid=%b want d=f7 valid=1", if_low.d, if_low.valid);
      miscompares++;
    end
    @(negedge clk);
    drive(1'b0, 3);
    @(posedge clk);
    #1;
    vectors++;
    if (if_low.d !== 8'hFF || if_low.valid !== 1'b0) begin
      $display("FAIL low_idle: got d=%h valid=%b want d=ff valid=0", if_low.d, if_low.valid);
      miscompares++;
    end
  endtask

  task automatic test_comb();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i);
      #1;
      vectors++;
      if (if_comb.d !== model(1'b1, i) || if_comb.valid !== 1'b1) begin
        $display("FAIL comb_%0d: got d=%h valid=%b want d=%h valid=1",
                 i, if_comb.d, if_comb.valid, model(1'b1, i));
        miscompares++;
      end
      #9;
    end
  endtask

  task automatic test_random();
    logic       e;
    int         idx;
    logic [7:0] exp_d;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      e   = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 7));
      drive(e, idx);
      rst_n = ($urandom_range(0, 49) != 0);
      #1;
      exp_d = rst_n ? model(e, idx) : 8'h00;
      vectors++;
      if (if_comb.d !== exp_d || if_comb.valid !== (exp_d != 8'h00)) begin
        $display("FAIL rand_comb_%0d: got d=%h valid=%b want d=%h", n, if_comb.d, if_comb.valid,
                 exp_d);
        miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (if_reg.d !== exp_d || if_reg.valid !== (exp_d != 8'h00)) begin
        $display("FAIL rand_reg_%0d: got d=%h valid=%b want d=%h", n, if_reg.d, if_reg.valid,
                 exp_d);
        miscompares++;
      end
      vectors++;
      if (if_low.d !== ~exp_d) begin
        $display("FAIL rand_low_%0d: got d=%h want d=%h", n, if_low.d, ~exp_d);
        miscompares++;
      end
      vectors++;
      if ($countones(if_reg.d) > 1 || if_reg.valid !== ($countones(if_reg.d) == 1)) begin
        $display("FAIL rand_onehot_%0d: got d=%h valid=%b want popcount<=1 and valid=popcount",
                 n, if_reg.d, if_reg.valid);
        miscompares++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 0);
    test_reset();
    test_sweep();
    test_enable();
    test_active_low();
    test_comb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
